// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the M-stage coprocessor-0 block.
//   - CP0 register indices used by mfc0/mtc0
//   - exception codes recorded in Cause.ExcCode
//   - SR/Cause field bit positions
//   - exception handler address, also used by the F-stage PC register
package cp0_pkg;

    // CP0 register indices
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Field bit positions
    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;

    // Fetch redirect target on interrupt/exception
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    // Assemble the architectural SR view; unlisted bits read as zero.
    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] v;
        v              = 32'd0;
        v[IM_HI:IM_LO] = im;
        v[EXL_BIT]     = exl;
        v[IE_BIT]      = ie;
        return v;
    endfunction

    // Assemble the architectural Cause view; unlisted bits read as zero.
    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v              = 32'd0;
        v[BD_BIT]      = bd;
        v[IM_HI:IM_LO] = ip;
        v[6:2]         = exc;
        return v;
    endfunction

endpackage

// File: rtl/m_cp0.sv
// m_cp0: coprocessor 0 at the M stage. Holds SR, Cause, EPC and PRId,
// arbitrates hardware interrupts against the M-stage exception code and
// raises Req, which redirects fetch to the handler and flushes the pipe.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   reset      in   asynchronous active-low reset
//   A1         in   mfc0 read index
//   A2         in   mtc0 write index
//   DIn        in   mtc0 write data
//   en         in   mtc0 write enable
//   PC         in   M-stage instruction PC
//   BDIn       in   M-stage instruction sits in a branch delay slot
//   ExcCodeIn  in   M-stage exception code, 0 = none
//   HWInt      in   level-sensitive hardware interrupt lines
//   EXLClr     in   eret in M stage
//   DOut       out  mfc0 read data (combinational)
//   EPCOut     out  current EPC
//   Req        out  interrupt/exception redirect request (combinational)
module m_cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_2024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        en,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;
    logic        bd_q,  bd_d;
    logic [5:0]  ip_q,  ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;
    logic [31:0] epc_trap;

    // Write-data and PC bits that have no home in any register.
    logic        unused_bits;
    assign unused_bits = ^{DIn[31:16], DIn[9:2], PC[1:0]};

    assign int_req    = ie_q & ~exl_q & (|(HWInt & im_q));
    assign exc_req    = ~exl_q & (ExcCodeIn != EXC_INT);
    assign Req        = int_req | exc_req;

    // A delay-slot instruction returns to its branch, one word earlier.
    // Wraparound at PC=0 is intentional.
    assign pc_aligned = {PC[31:2], 2'b00};
    assign epc_trap   = BDIn ? (pc_aligned - 32'd4) : pc_aligned;

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = HWInt;

        if (Req) begin
            // Trap entry: the M-stage instruction is flushed, so any mtc0
            // or eret it carries is dropped.
            exl_d = 1'b1;
            exc_d = int_req ? EXC_INT : ExcCodeIn;
            bd_d  = BDIn;
            epc_d = epc_trap;
        end else begin
            if (en && (A2 == REG_SR)) begin
                im_d  = DIn[IM_HI:IM_LO];
                exl_d = DIn[EXL_BIT];
                ie_d  = DIn[IE_BIT];
            end
            if (en && (A2 == REG_EPC)) begin
                epc_d = DIn;
            end
            // eret overrides an EXL value written by a simultaneous mtc0.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= 6'd0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= 6'd0;
            exc_q <= 5'd0;
            epc_q <= 32'd0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    assign EPCOut = epc_q;

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = pack_sr(im_q, exl_q, ie_q);
            REG_CAUSE: DOut = pack_cause(bd_q, ip_q, exc_q);
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID;
            default:   DOut = 32'd0;
        endcase
    end

endmodule
